// File: rtl/siw_memory_bram_dly_param.sv
// Dual-port single-clock SIW memory with a per-port programmable write-delay pipeline.
// Optional clear sequencer is built when SIW_BRAM_CLEAR_EN is defined.
module siw_memory_bram_dly_param #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 14,
  parameter int MAX_DLY = 3,
  parameter int CONF_W  = 2
) (
  input  logic              siw_memory_bram_6_clk_a,
  input  logic              siw_memory_bram_6_reset,
  input  logic              siw_memory_bram_6_init,
  input  logic              siw_memory_bram_6_mem_sel,
  input  logic              siw_memory_bram_6_enable_a,
  input  logic              siw_memory_bram_6_enable_b,
  input  logic              siw_memory_bram_6_write_en_a,
  input  logic              siw_memory_bram_6_write_en_b,
  input  logic [ADDR_W-1:0] siw_memory_bram_6_address_a,
  input  logic [ADDR_W-1:0] siw_memory_bram_6_address_b,
  input  logic [DATA_W-1:0] siw_memory_bram_6_input_data_a,
  input  logic [DATA_W-1:0] siw_memory_bram_6_input_data_b,
  input  logic [CONF_W-1:0] siw_memory_bram_6_mem_conf_a,
  input  logic [CONF_W-1:0] siw_memory_bram_6_mem_conf_b,
  output logic [DATA_W-1:0] siw_memory_bram_6_output_data_a,
  output logic [DATA_W-1:0] siw_memory_bram_6_output_data_b,
  output logic              siw_memory_bram_6_busy,
  output logic              siw_memory_bram_6_done
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [CONF_W-1:0] MAX_CONF = CONF_W'(MAX_DLY);

  function automatic logic [CONF_W-1:0] sat_dly(input logic [CONF_W-1:0] conf);
    return (conf > MAX_CONF) ? MAX_CONF : conf;
  endfunction

  logic              vld_a_p  [1:MAX_DLY];
  logic              vld_b_p  [1:MAX_DLY];
  logic [ADDR_W-1:0] addr_a_p [1:MAX_DLY];
  logic [ADDR_W-1:0] addr_b_p [1:MAX_DLY];
  logic [DATA_W-1:0] data_a_p [1:MAX_DLY];
  logic [DATA_W-1:0] data_b_p [1:MAX_DLY];

  logic [CONF_W-1:0] dly_a, dly_b;
  logic              sel_we_a, sel_we_b;
  logic [ADDR_W-1:0] sel_addr_a, sel_addr_b;
  logic [DATA_W-1:0] sel_data_a, sel_data_b;
  logic              wen_a, wen_b;
  logic              clearing;
  logic [ADDR_W-1:0] clr_addr;
  logic [DATA_W-1:0] rd_a_p1, rd_b_p1;
  logic [DATA_W-1:0] mem [DEPTH];

  // Delay stages 1..MAX_DLY: valid is control (reset/flushed), payload is not.
  always_ff @(posedge siw_memory_bram_6_clk_a or posedge siw_memory_bram_6_reset) begin
    if (siw_memory_bram_6_reset || siw_memory_bram_6_init) begin
      for (int k = 1; k <= MAX_DLY; k++) begin
        vld_a_p[k] <= 1'b0;
        vld_b_p[k] <= 1'b0;
      end
    end else begin
      vld_a_p[1] <= siw_memory_bram_6_write_en_a;
      vld_b_p[1] <= siw_memory_bram_6_write_en_b;
      for (int k = 2; k <= MAX_DLY; k++) begin
        vld_a_p[k] <= vld_a_p[k-1];
        vld_b_p[k] <= vld_b_p[k-1];
      end
    end
  end

  always_ff @(posedge siw_memory_bram_6_clk_a) begin
    addr_a_p[1] <= siw_memory_bram_6_address_a;
    addr_b_p[1] <= siw_memory_bram_6_address_b;
    data_a_p[1] <= siw_memory_bram_6_input_data_a;
    data_b_p[1] <= siw_memory_bram_6_input_data_b;
    for (int k = 2; k <= MAX_DLY; k++) begin
      addr_a_p[k] <= addr_a_p[k-1];
      addr_b_p[k] <= addr_b_p[k-1];
      data_a_p[k] <= data_a_p[k-1];
      data_b_p[k] <= data_b_p[k-1];
    end
  end

  // Stage 0 is the live input; the saturated conf picks which stage commits.
  always_comb begin
    dly_a      = sat_dly(siw_memory_bram_6_mem_conf_a);
    dly_b      = sat_dly(siw_memory_bram_6_mem_conf_b);
    sel_we_a   = siw_memory_bram_6_write_en_a;
    sel_addr_a = siw_memory_bram_6_address_a;
    sel_data_a = siw_memory_bram_6_input_data_a;
    sel_we_b   = siw_memory_bram_6_write_en_b;
    sel_addr_b = siw_memory_bram_6_address_b;
    sel_data_b = siw_memory_bram_6_input_data_b;
    for (int k = 1; k <= MAX_DLY; k++) begin
      if (int'(dly_a) == k) begin
        sel_we_a   = vld_a_p[k];
        sel_addr_a = addr_a_p[k];
        sel_data_a = data_a_p[k];
      end
      if (int'(dly_b) == k) begin
        sel_we_b   = vld_b_p[k];
        sel_addr_b = addr_b_p[k];
        sel_data_b = data_b_p[k];
      end
    end
  end

  assign wen_a = sel_we_a & (siw_memory_bram_6_enable_a | siw_memory_bram_6_mem_sel) & ~clearing;
  assign wen_b = sel_we_b & siw_memory_bram_6_enable_b & ~clearing;

`ifdef SIW_BRAM_CLEAR_EN
  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;
  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;

  always_ff @(posedge siw_memory_bram_6_clk_a or posedge siw_memory_bram_6_reset) begin
    if (siw_memory_bram_6_reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: if (siw_memory_bram_6_init) begin
        state_nxt = CLEAR;
        cnt_nxt   = '0;
      end
      CLEAR: begin
        if (siw_memory_bram_6_init) cnt_nxt = '0;
        else if (cnt == '1)         state_nxt = DONE;
        else                        cnt_nxt = cnt + 1'b1;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign clearing               = (state == CLEAR);
  assign clr_addr               = cnt;
  assign siw_memory_bram_6_busy = clearing;
  assign siw_memory_bram_6_done = (state == DONE);
`else
  assign clearing               = 1'b0;
  assign clr_addr               = '0;
  assign siw_memory_bram_6_busy = 1'b0;
  assign siw_memory_bram_6_done = 1'b0;
`endif

  // Array: B written before A so A wins a same-address collision; reads are read-first.
  always_ff @(posedge siw_memory_bram_6_clk_a) begin
    if (clearing) mem[clr_addr] <= '0;
    if (wen_b)    mem[sel_addr_b] <= sel_data_b;
    if (wen_a)    mem[sel_addr_a] <= sel_data_a;
    rd_a_p1 <= mem[siw_memory_bram_6_address_a];
    rd_b_p1 <= mem[siw_memory_bram_6_address_b];
  end

  // Output register stage.
  always_ff @(posedge siw_memory_bram_6_clk_a or posedge siw_memory_bram_6_reset) begin
    if (siw_memory_bram_6_reset) begin
      siw_memory_bram_6_output_data_a <= '0;
      siw_memory_bram_6_output_data_b <= '0;
    end else begin
      siw_memory_bram_6_output_data_a <= rd_a_p1;
      siw_memory_bram_6_output_data_b <= rd_b_p1;
    end
  end

endmodule

// File: tb/tb_siw_memory_bram_dly_param.sv
// Randomized bench for siw_memory_bram_dly_param against a write-scheduling reference model.
// Clear-sequencer scenarios run when SIW_BRAM_CLEAR_EN is defined.
module tb_siw_memory_bram_dly_param;

  logic        clk = 1'b0;
  logic        reset, init, mem_sel, en_a, en_b, we_a, we_b;
  logic [3:0]  addr_a, addr_b;
  logic [31:0] din_a, din_b, dout_a, dout_b;
  logic [1:0]  conf_a, conf_b;
  logic        busy, done;

  siw_memory_bram_dly_param #(.DATA_W(32), .ADDR_W(4), .MAX_DLY(3), .CONF_W(2)) dut (
    .siw_memory_bram_6_clk_a(clk),
    .siw_memory_bram_6_reset(reset),
    .siw_memory_bram_6_init(init),
    .siw_memory_bram_6_mem_sel(mem_sel),
    .siw_memory_bram_6_enable_a(en_a),
    .siw_memory_bram_6_enable_b(en_b),
    .siw_memory_bram_6_write_en_a(we_a),
    .siw_memory_bram_6_write_en_b(we_b),
    .siw_memory_bram_6_address_a(addr_a),
    .siw_memory_bram_6_address_b(addr_b),
    .siw_memory_bram_6_input_data_a(din_a),
    .siw_memory_bram_6_input_data_b(din_b),
    .siw_memory_bram_6_mem_conf_a(conf_a),
    .siw_memory_bram_6_mem_conf_b(conf_b),
    .siw_memory_bram_6_output_data_a(dout_a),
    .siw_memory_bram_6_output_data_b(dout_b),
    .siw_memory_bram_6_busy(busy),
    .siw_memory_bram_6_done(done)
  );

  always #5 clk = ~clk;

  // Reference model: each write is scheduled to land at issue cycle + delay.
  typedef struct {int port; int due; logic [3:0] addr; logic [31:0] data;} wr_t;
  wr_t         pend[$];
  logic [31:0] mem_m [16];
  logic [31:0] rd_a_m, rd_b_m, exp_a, exp_b;
  logic        exp_busy, exp_done;
  int          clr_cnt = -1;
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;

  function automatic int sat(input logic [1:0] c);
    return (int'(c) > 3) ? 3 : int'(c);
  endfunction

  task automatic tick();
    logic [31:0] nxt_a, nxt_b;
    logic        done_nxt;
    bit          clearing;
    wr_t         w;
    nxt_a    = mem_m[addr_a];
    nxt_b    = mem_m[addr_b];
    done_nxt = 1'b0;
    if (reset) begin
      pend.delete();
      clr_cnt = -1;
    end else begin
      if (we_a) begin w.port = 0; w.due = cyc + sat(conf_a); w.addr = addr_a; w.data = din_a; pend.push_back(w); end
      if (we_b) begin w.port = 1; w.due = cyc + sat(conf_b); w.addr = addr_b; w.data = din_b; pend.push_back(w); end
      clearing = (clr_cnt >= 0);
      for (int p = 1; p >= 0; p--)
        foreach (pend[i])
          if (pend[i].port == p && pend[i].due == cyc && !clearing &&
              ((p == 0) ? (en_a | mem_sel) : en_b))
            mem_m[pend[i].addr] = pend[i].data;
      for (int i = pend.size() - 1; i >= 0; i--)
        if (pend[i].due <= cyc) pend.delete(i);
      if (init) pend.delete();
`ifdef SIW_BRAM_CLEAR_EN
      if (clearing) begin
        mem_m[clr_cnt] = 32'h0;
        if (init) clr_cnt = 0;
        else if (clr_cnt == 15) begin clr_cnt = -1; done_nxt = 1'b1; end
        else clr_cnt++;
      end else if (init && !exp_done) begin
        clr_cnt = 0;
      end
`endif
    end
    @(posedge clk); #1;
    cyc++;
    exp_a    = reset ? 32'h0 : rd_a_m;
    exp_b    = reset ? 32'h0 : rd_b_m;
    rd_a_m   = nxt_a;
    rd_b_m   = nxt_b;
    exp_done = reset ? 1'b0 : done_nxt;
    exp_busy = (clr_cnt >= 0);
  endtask

  task automatic idle_inputs();
    init = 0; mem_sel = 0; en_a = 1; en_b = 1; we_a = 0; we_b = 0;
    addr_a = 0; addr_b = 0; din_a = 0; din_b = 0; conf_a = 0; conf_b = 0;
  endtask

  task automatic preload();
    idle_inputs();
    for (int i = 0; i < 16; i++) begin
      we_a = 1; addr_a = 4'(i); din_a = $urandom | 32'h1;
      tick();
    end
    we_a = 0;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1;
    exp_busy = 0; exp_done = 0;
    tick(); tick();
    if (dout_a !== 32'h0) begin errors++; $display("FAIL reset_dout_a: got %h want 0", dout_a); end
    checks++;
    if (dout_b !== 32'h0) begin errors++; $display("FAIL reset_dout_b: got %h want 0", dout_b); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++;
    reset = 0;
    tick(); tick();
  endtask

  task automatic test_basic();
    idle_inputs();
    we_a = 1; addr_a = 5; din_a = 32'hDEADBEEF;
    tick();
    we_a = 0; addr_a = 5;
    tick(); tick();
    if (dout_a !== 32'hDEADBEEF) begin errors++; $display("FAIL basic_read: got %h want deadbeef", dout_a); end
    checks++;
    if (dout_a !== exp_a) begin errors++; $display("FAIL basic_model: got %h want %h", dout_a, exp_a); end
    checks++;
  endtask

  task automatic test_delay();
    idle_inputs();
    conf_a = 2; addr_b = 3;
    we_a = 1; addr_a = 3; din_a = 32'h11;
    tick();
    we_a = 0; addr_a = 4'hF; din_a = 32'hFF;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (dout_b !== exp_b) begin errors++; $display("FAIL delay_timing[%0d]: got %h want %h", i, dout_b, exp_b); end
      checks++;
    end
    if (dout_b !== 32'h11) begin errors++; $display("FAIL delay_value: got %h want 11", dout_b); end
    checks++;
    addr_b = 4'hF;
    tick(); tick();
    if (dout_b !== exp_b) begin errors++; $display("FAIL delay_untouched_f: got %h want %h", dout_b, exp_b); end
    checks++;
    conf_a = 0;
  endtask

  task automatic test_collision();
    idle_inputs();
    we_a = 1; addr_a = 7; din_a = 32'hAAAA;
    we_b = 1; addr_b = 7; din_b = 32'hBBBB;
    tick();
    we_a = 0; we_b = 0;
    tick(); tick();
    if (dout_a !== 32'hAAAA) begin errors++; $display("FAIL collision_a_wins: got %h want aaaa", dout_a); end
    checks++;
    if (dout_b !== exp_b) begin errors++; $display("FAIL collision_b_read: got %h want %h", dout_b, exp_b); end
    checks++;
  endtask

  task automatic test_init_flush();
    logic [31:0] wdata;
    idle_inputs();
    conf_b = 3;
    wdata = ~mem_m[9];
    we_b = 1; addr_b = 9; din_b = wdata;
    tick();
    we_b = 0; init = 1;
    tick();
    init = 0;
    for (int i = 0; i < 24; i++) begin
      tick();
      if (busy !== exp_busy || done !== exp_done) begin
        errors++; $display("FAIL flush_status[%0d]: got busy=%b done=%b want busy=%b done=%b", i, busy, done, exp_busy, exp_done);
      end
      checks++;
    end
    addr_a = 9;
    tick(); tick();
    if (dout_a === wdata) begin errors++; $display("FAIL flush_dropped: got %h which must not be %h", dout_a, wdata); end
    checks++;
    if (dout_a !== exp_a) begin errors++; $display("FAIL flush_model: got %h want %h", dout_a, exp_a); end
    checks++;
  endtask

  task automatic test_random();
    idle_inputs();
    for (int b = 0; b < 8; b++) begin
      conf_a = 2'($urandom_range(0, 3));
      conf_b = 2'($urandom_range(0, 3));
      for (int i = 0; i < 23; i++) begin
        we_a = (i < 20) ? 1'($urandom_range(0, 1)) : 1'b0;
        we_b = (i < 20) ? 1'($urandom_range(0, 1)) : 1'b0;
        addr_a = 4'($urandom); addr_b = 4'($urandom);
        din_a = $urandom; din_b = $urandom;
        en_a = ($urandom_range(0, 3) != 0);
        en_b = ($urandom_range(0, 3) != 0);
        mem_sel = ($urandom_range(0, 3) == 0);
        tick();
        if (dout_a !== exp_a || dout_b !== exp_b) begin
          errors++; $display("FAIL random[%0d.%0d]: got a=%h b=%h want a=%h b=%h", b, i, dout_a, dout_b, exp_a, exp_b);
        end
        checks++;
      end
    end
    idle_inputs();
    tick();
  endtask

`ifdef SIW_BRAM_CLEAR_EN
  task automatic test_clear();
    int busy_cnt, done_cnt;
    idle_inputs();
    busy_cnt = 0; done_cnt = 0;
    init = 1;
    tick();
    init = 0;
    for (int i = 0; i < 20; i++) begin
      we_a = (i == 5); addr_a = 4; din_a = 32'h1234;
      tick();
      if (busy !== exp_busy || done !== exp_done) begin
        errors++; $display("FAIL clear_status[%0d]: got busy=%b done=%b want busy=%b done=%b", i, busy, done, exp_busy, exp_done);
      end
      checks++;
      busy_cnt += int'(busy);
      done_cnt += int'(done);
    end
    we_a = 0;
    if (busy_cnt != 16) begin errors++; $display("FAIL clear_busy_len: got %0d want 16", busy_cnt); end
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL clear_done_pulses: got %0d want 1", done_cnt); end
    checks++;
    for (int i = 0; i < 16; i++) begin
      addr_a = 4'(i);
      tick(); tick();
      if (dout_a !== 32'h0 || dout_a !== exp_a) begin
        errors++; $display("FAIL clear_zero[%0d]: got %h want 0", i, dout_a);
      end
      checks++;
    end
  endtask

  task automatic test_reset_mid_clear();
    idle_inputs();
    init = 1;
    tick();
    init = 0;
    repeat (8) tick();
    reset = 1;
    #1;
    pend.delete(); clr_cnt = -1;
    exp_a = 0; exp_b = 0; exp_busy = 0; exp_done = 0;
    if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
    checks++;
    if (dout_a !== 32'h0 || dout_b !== 32'h0) begin errors++; $display("FAIL abort_dout: got a=%h b=%h want 0", dout_a, dout_b); end
    checks++;
    tick();
    reset = 0;
    tick();
    for (int i = 0; i < 16; i++) begin
      addr_b = 4'(i);
      tick(); tick();
      if (dout_b !== exp_b || (i < 8 && dout_b !== 32'h0) || (i >= 8 && dout_b === 32'h0)) begin
        errors++; $display("FAIL abort_contents[%0d]: got %h want %h", i, dout_b, exp_b);
      end
      checks++;
    end
  endtask
`endif

  initial begin
    reset = 1;
    test_reset();
    preload();
    test_basic();
    test_delay();
    test_collision();
    test_init_flush();
    preload();
    test_random();
`ifdef SIW_BRAM_CLEAR_EN
    preload();
    test_clear();
    preload();
    test_reset_mid_clear();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
